trigger_sequencer: RTL and testbench

//  Multi-stage capture trigger for the logic analyzer: per-channel rise/fall/level conditions, up to NUM_STAGES sequential stages.

---
 rtl/trigger_pkg.sv | 35 +++
 rtl/trigger_stage_match.sv | 27 ++
 rtl/trigger_sequencer.sv | 175 +++++++++++++++++
 tb/tb_trigger_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared types and helpers for the multi-stage capture trigger
// Contents:
//   TRIG_SAMPLE_W / TRIG_COUNT_W : field widths of the stored stage configuration
//   stage_cfg_t                  : one stage's rise/fall/level conditions, repeat count, last flag
//   trig_state_t                 : sequencer FSM states (ST_DELAY only with TRIG_DELAY_EN)
//   stage_w()                    : stage index width, minimum 1 bit
package trigger_pkg;

    localparam int TRIG_SAMPLE_W = 8;
    localparam int TRIG_COUNT_W  = 16;

    typedef struct packed {
        logic [TRIG_SAMPLE_W-1:0] rise;
        logic [TRIG_SAMPLE_W-1:0] fall;
        logic [TRIG_SAMPLE_W-1:0] lvl_mask;
        logic [TRIG_SAMPLE_W-1:0] lvl_val;
        logic [TRIG_COUNT_W-1:0]  count;
        logic                     last;
    } stage_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_ARMED,
`ifdef TRIG_DELAY_EN
        ST_DELAY,
`endif
        ST_FIRE
    } trig_state_t;

    function automatic int stage_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trigger_stage_match.sv
// rtl/trigger_stage_match.sv - combinational match of one stage's conditions against a sample
// Ports:
//   rise, fall       : per-channel edge selects (both set = any edge)
//   lvl_mask, lvl_val: per-channel level check enable and required level
//   data, prev       : current sample and previous valid sample
//   match            : every channel satisfies all of its selected conditions
module trigger_stage_match #(
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic [SAMPLE_WIDTH-1:0] rise,
    input  logic [SAMPLE_WIDTH-1:0] fall,
    input  logic [SAMPLE_WIDTH-1:0] lvl_mask,
    input  logic [SAMPLE_WIDTH-1:0] lvl_val,
    input  logic [SAMPLE_WIDTH-1:0] data,
    input  logic [SAMPLE_WIDTH-1:0] prev,
    output logic                    match
);

    logic [SAMPLE_WIDTH-1:0] edge_ok;
    logic [SAMPLE_WIDTH-1:0] lvl_ok;

    // With rise and fall both selected the two terms OR to data^prev.
    assign edge_ok = ~(rise | fall) | (rise & data & ~prev) | (fall & ~data & prev);
    assign lvl_ok  = ~lvl_mask | ~(data ^ lvl_val);
    assign match   = &(edge_ok & lvl_ok);

endmodule

// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - multi-stage sequential capture trigger producing a one-clock run pulse
// Optional feature macro: TRIG_DELAY_EN (adds load_delay/cfg_delay and a post-match delay state)
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   valid, dataIn           : sample strobe and sample bus
//   arm, abort              : start sequence at stage 0 / return to idle without firing
//   load, load_stage, cfg_* : write one stage's configuration (accepted in idle only)
//   load_delay, cfg_delay   : post-trigger delay in valid samples (TRIG_DELAY_EN only)
//   run                     : one-clock trigger pulse to capture control
//   armed, stage            : sequencer active flag and current stage index
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int  SAMPLE_WIDTH = TRIG_SAMPLE_W,
    parameter int  NUM_STAGES   = 4,
    parameter int  COUNT_WIDTH  = TRIG_COUNT_W,
    parameter int  DELAY_WIDTH  = 16,
    localparam int STAGE_W      = stage_w(NUM_STAGES)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    valid,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    load,
    input  logic [STAGE_W-1:0]      load_stage,
    input  logic [SAMPLE_WIDTH-1:0] cfg_rise,
    input  logic [SAMPLE_WIDTH-1:0] cfg_fall,
    input  logic [SAMPLE_WIDTH-1:0] cfg_lvl_mask,
    input  logic [SAMPLE_WIDTH-1:0] cfg_lvl_val,
    input  logic [COUNT_WIDTH-1:0]  cfg_count,
    input  logic                    cfg_last,
`ifdef TRIG_DELAY_EN
    input  logic                    load_delay,
    input  logic [DELAY_WIDTH-1:0]  cfg_delay,
`endif
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    output logic                    run,
    output logic                    armed,
    output logic [STAGE_W-1:0]      stage
);

    stage_cfg_t              cfg_q [NUM_STAGES];
    stage_cfg_t              cur;
    trig_state_t             state_q, state_d;
    logic [STAGE_W-1:0]      stage_q, stage_d;
    logic [COUNT_WIDTH-1:0]  mcount_q, mcount_d;
    logic [SAMPLE_WIDTH-1:0] prev_q;
    logic                    stage_hit;
    logic                    is_final;
`ifdef TRIG_DELAY_EN
    logic [DELAY_WIDTH-1:0]  delay_q;
    logic [DELAY_WIDTH-1:0]  dcount_q, dcount_d;
`endif

    assign cur      = cfg_q[stage_q];
    assign is_final = cur.last || (32'(stage_q) == NUM_STAGES - 1);

    trigger_stage_match #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_match (
        .rise     (cur.rise),
        .fall     (cur.fall),
        .lvl_mask (cur.lvl_mask),
        .lvl_val  (cur.lvl_val),
        .data     (dataIn),
        .prev     (prev_q),
        .match    (stage_hit)
    );

    // Configuration storage and previous-sample register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STAGES; i++) cfg_q[i] <= '0;
            prev_q <= '0;
`ifdef TRIG_DELAY_EN
            delay_q <= '0;
`endif
        end else begin
            if (valid) prev_q <= dataIn;
            if (load && state_q == ST_IDLE && 32'(load_stage) < NUM_STAGES)
                cfg_q[load_stage] <= '{rise: cfg_rise, fall: cfg_fall, lvl_mask: cfg_lvl_mask,
                                       lvl_val: cfg_lvl_val, count: cfg_count, last: cfg_last};
`ifdef TRIG_DELAY_EN
            if (load_delay && state_q == ST_IDLE) delay_q <= cfg_delay;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            stage_q  <= '0;
            mcount_q <= '0;
`ifdef TRIG_DELAY_EN
            dcount_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            mcount_q <= mcount_d;
`ifdef TRIG_DELAY_EN
            dcount_q <= dcount_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        mcount_d = mcount_q;
`ifdef TRIG_DELAY_EN
        dcount_d = dcount_q;
`endif
        if (abort) begin
            state_d  = ST_IDLE;
            stage_d  = '0;
            mcount_d = '0;
`ifdef TRIG_DELAY_EN
            dcount_d = '0;
`endif
        end else if (arm) begin
            state_d  = ST_PRIME;
            stage_d  = '0;
            mcount_d = '0;
`ifdef TRIG_DELAY_EN
            dcount_d = '0;
`endif
        end else begin
            case (state_q)
                // First sample after arm only seeds prev_q.
                ST_PRIME: if (valid) state_d = ST_ARMED;
                ST_ARMED: begin
                    if (valid && stage_hit) begin
                        if (mcount_q == cur.count) begin
                            mcount_d = '0;
                            if (is_final) begin
`ifdef TRIG_DELAY_EN
                                dcount_d = '0;
                                state_d  = (delay_q == '0) ? ST_FIRE : ST_DELAY;
`else
                                state_d  = ST_FIRE;
`endif
                            end else begin
                                stage_d = stage_q + 1'b1;
                            end
                        end else begin
                            mcount_d = mcount_q + 1'b1;
                        end
                    end
                end
`ifdef TRIG_DELAY_EN
                ST_DELAY: begin
                    if (valid) begin
                        if (dcount_q == delay_q - 1'b1) state_d = ST_FIRE;
                        else dcount_d = dcount_q + 1'b1;
                    end
                end
`endif
                ST_FIRE: begin
                    state_d = ST_IDLE;
                    stage_d = '0;
                end
                default: ;
            endcase
        end
    end

    assign run   = (state_q == ST_FIRE);
`ifdef TRIG_DELAY_EN
    assign armed = (state_q == ST_PRIME) || (state_q == ST_ARMED) || (state_q == ST_DELAY);
`else
    assign armed = (state_q == ST_PRIME) || (state_q == ST_ARMED);
`endif
    assign stage = stage_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - self-checking bench for trigger_sequencer
module tb_trigger_sequencer;

    localparam int SW = 8;
    localparam int NS = 4;
    localparam int CW = 16;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          valid, arm, abort, load;
    logic [1:0]    load_stage;
    logic [SW-1:0] cfg_rise, cfg_fall, cfg_lvl_mask, cfg_lvl_val, dataIn;
    logic [CW-1:0] cfg_count;
    logic          cfg_last;
    logic          run, armed;
    logic [1:0]    stage;
`ifdef TRIG_DELAY_EN
    logic          load_delay;
    logic [DW-1:0] cfg_delay;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    trigger_sequencer #(.SAMPLE_WIDTH(SW), .NUM_STAGES(NS), .COUNT_WIDTH(CW), .DELAY_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n), .valid(valid), .arm(arm), .abort(abort),
        .load(load), .load_stage(load_stage), .cfg_rise(cfg_rise), .cfg_fall(cfg_fall),
        .cfg_lvl_mask(cfg_lvl_mask), .cfg_lvl_val(cfg_lvl_val), .cfg_count(cfg_count),
        .cfg_last(cfg_last),
`ifdef TRIG_DELAY_EN
        .load_delay(load_delay), .cfg_delay(cfg_delay),
`endif
        .dataIn(dataIn), .run(run), .armed(armed), .stage(stage)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 0; arm = 0; abort = 0; load = 0; load_stage = 0;
        cfg_rise = 0; cfg_fall = 0; cfg_lvl_mask = 0; cfg_lvl_val = 0; cfg_count = 0; cfg_last = 0;
`ifdef TRIG_DELAY_EN
        load_delay = 0; cfg_delay = 0;
`endif
    endtask

    task automatic apply_reset();
        idle_inputs();
        dataIn = 0;
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        tick();
    endtask

    task automatic load_cfg(input int s, input logic [7:0] r, f, m, v, input logic [15:0] c, input logic l);
        load = 1; load_stage = 2'(s);
        cfg_rise = r; cfg_fall = f; cfg_lvl_mask = m; cfg_lvl_val = v; cfg_count = c; cfg_last = l;
        tick();
        load = 0;
    endtask

    task automatic clear_cfg();
        for (int s = 0; s < NS; s++) load_cfg(s, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_arm();
        arm = 1; tick(); arm = 0;
    endtask

    task automatic to_idle();
        abort = 1; tick(); abort = 0;
    endtask

    task automatic sample(input logic [7:0] d);
        dataIn = d; valid = 1; tick(); valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        dataIn = 0;
        reset_n = 0;
        #3;
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", run); end
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed got %b want 0", armed); end
        checks++; if (stage !== 2'd0) begin errors++; $display("FAIL reset_stage got %0d want 0", stage); end
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic test_single_rise();
        clear_cfg();
        load_cfg(0, 8'h01, 0, 0, 0, 0, 1);
        do_arm();
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL rise_armed got %b want 1", armed); end
        sample(8'h00);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL rise_prime_run got %b want 0", run); end
        sample(8'h01);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL rise_run got %b want 1", run); end
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL rise_armed_drop got %b want 0", armed); end
        tick();
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL rise_run_width got %b want 0", run); end
    endtask

    task automatic test_prime_stale();
        sample(8'h00);
        dataIn = 8'h01;
        do_arm();
        sample(8'h01);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL stale_run got %b want 0", run); end
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL stale_armed got %b want 1", armed); end
        sample(8'h00);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL stale_fall_run got %b want 0", run); end
        sample(8'h01);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL stale_rise_run got %b want 1", run); end
        tick();
    endtask

    task automatic setup_multi();
        clear_cfg();
        load_cfg(0, 0, 0, 8'hF0, 8'hA0, 16'd2, 0);
        load_cfg(1, 0, 8'h80, 0, 0, 16'd0, 1);
    endtask

    task automatic test_multi_stage();
        setup_multi();
        do_arm();
        sample(8'h00);
        sample(8'hA5); sample(8'hA5);
        checks++; if (stage !== 2'd0) begin errors++; $display("FAIL multi_two_stage got %0d want 0", stage); end
        sample(8'hA5);
        checks++; if (stage !== 2'd1) begin errors++; $display("FAIL multi_three_stage got %0d want 1", stage); end
        sample(8'h80);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL multi_nofall_run got %b want 0", run); end
        sample(8'h00);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL multi_run got %b want 1", run); end
        tick();
    endtask

    task automatic test_two_only();
        do_arm();
        sample(8'h00);
        sample(8'hA5); sample(8'hA5); sample(8'h00); sample(8'h3C);
        checks++; if (stage !== 2'd0) begin errors++; $display("FAIL two_only_stage got %0d want 0", stage); end
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL two_only_armed got %b want 1", armed); end
        to_idle();
    endtask

    task automatic test_abort_mid();
        do_arm();
        sample(8'h00);
        sample(8'hA5); sample(8'hA5); sample(8'hA5);
        checks++; if (stage !== 2'd1) begin errors++; $display("FAIL abort_pre_stage got %0d want 1", stage); end
        to_idle();
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL abort_armed got %b want 0", armed); end
        sample(8'h80); sample(8'h00);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL abort_run got %b want 0", run); end
        do_arm();
        arm = 1; abort = 1; tick(); arm = 0; abort = 0;
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL arm_abort_armed got %b want 0", armed); end
    endtask

    task automatic test_load_while_armed();
        do_arm();
        sample(8'h00);
        load_cfg(0, 0, 0, 0, 0, 16'd0, 1);
        sample(8'hA5);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL load_armed_run1 got %b want 0", run); end
        sample(8'hA5);
        checks++; if (stage !== 2'd0) begin errors++; $display("FAIL load_armed_stage0 got %0d want 0", stage); end
        sample(8'hA5);
        checks++; if (stage !== 2'd1) begin errors++; $display("FAIL load_armed_stage1 got %0d want 1", stage); end
        to_idle();
    endtask

    task automatic test_load_and_arm();
        arm = 1;
        load_cfg(0, 0, 0, 0, 0, 16'd0, 1);
        arm = 0;
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL load_arm_armed got %b want 1", armed); end
        sample(8'h5A);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL load_arm_prime got %b want 0", run); end
        sample(8'h5A);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL load_arm_run got %b want 1", run); end
        tick();
    endtask

    task automatic test_async_reset();
        clear_cfg();
        do_arm();
        sample(8'h11); sample(8'h22); sample(8'h33);
        checks++; if (stage !== 2'd2) begin errors++; $display("FAIL async_pre_stage got %0d want 2", stage); end
        #2 reset_n = 0;
        #1;
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL async_armed got %b want 0", armed); end
        checks++; if (stage !== 2'd0) begin errors++; $display("FAIL async_stage got %0d want 0", stage); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL async_run got %b want 0", run); end
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic test_default_cfg();
        do_arm();
        for (int i = 0; i < 4; i++) sample(8'($urandom));
        checks++; if (stage !== 2'd3) begin errors++; $display("FAIL default_stage got %0d want 3", stage); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL default_early_run got %b want 0", run); end
        sample(8'($urandom));
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL default_run got %b want 1", run); end
        tick();
    endtask

`ifdef TRIG_DELAY_EN
    task automatic test_delay();
        load_delay = 1; cfg_delay = 16'd3; tick(); load_delay = 0;
        load_cfg(0, 8'h01, 0, 0, 0, 0, 1);
        do_arm();
        sample(8'h00); sample(8'h01);
        checks++; if (run !== 1'b0 || armed !== 1'b1) begin errors++; $display("FAIL delay_match run %b armed %b want 0 1", run, armed); end
        tick();
        sample(8'h10);
        tick(); tick();
        sample(8'h20);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL delay_early got %b want 0", run); end
        tick();
        sample(8'h30);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL delay_run got %b want 1", run); end
        tick();
    endtask
`endif

    // Reference model: phase 0 idle, 1 waiting for priming sample, 2 matching, 4 firing.
    task automatic test_random();
        logic [7:0]  mr [NS], mf [NS], mm [NS], mv [NS];
        logic [15:0] mc [NS];
        logic        ml [NS];
        logic [7:0]  mp;
        int          phase, stg, hits;
        logic        hit, d, p;
        apply_reset();
        for (int s = 0; s < NS; s++) begin
            mr[s] = 0; mf[s] = 0; mm[s] = 0; mv[s] = 0; mc[s] = 0; ml[s] = 0;
        end
        mp = 0; phase = 0; stg = 0; hits = 0;
        for (int n = 0; n < 2000; n++) begin
            valid        = ($urandom % 4) != 0;
            dataIn       = 8'($urandom);
            arm          = (phase == 0) ? (($urandom % 6) == 0) : (($urandom % 50) == 0);
            abort        = ($urandom % 70) == 0;
            load         = ($urandom % 8) == 0;
            load_stage   = 2'($urandom);
            cfg_rise     = ($urandom % 2) ? 8'(1 << ($urandom % 8)) : 8'h00;
            cfg_fall     = ($urandom % 3 == 0) ? 8'(1 << ($urandom % 8)) : 8'h00;
            cfg_lvl_mask = ($urandom % 2) ? 8'(1 << ($urandom % 8)) : 8'h00;
            cfg_lvl_val  = 8'($urandom);
            cfg_count    = 16'($urandom % 3);
            cfg_last     = ($urandom % 3) == 0;

            hit = 1'b1;
            for (int i = 0; i < SW; i++) begin
                d = dataIn[i]; p = mp[i];
                if (mr[stg][i] && mf[stg][i]) hit &= (d != p);
                else if (mr[stg][i]) hit &= (d && !p);
                else if (mf[stg][i]) hit &= (!d && p);
                if (mm[stg][i]) hit &= (d == mv[stg][i]);
            end
            if (load && phase == 0) begin
                mr[load_stage] = cfg_rise; mf[load_stage] = cfg_fall;
                mm[load_stage] = cfg_lvl_mask; mv[load_stage] = cfg_lvl_val;
                mc[load_stage] = cfg_count; ml[load_stage] = cfg_last;
            end
            if (abort) begin
                phase = 0; stg = 0; hits = 0;
            end else if (arm) begin
                phase = 1; stg = 0; hits = 0;
            end else if (phase == 1) begin
                if (valid) phase = 2;
            end else if (phase == 2) begin
                if (valid && hit) begin
                    if (hits == int'(mc[stg])) begin
                        hits = 0;
                        if (ml[stg] || stg == NS - 1) phase = 4;
                        else stg++;
                    end else hits++;
                end
            end else if (phase == 4) begin
                phase = 0; stg = 0;
            end
            if (valid) mp = dataIn;

            tick();
            checks++; if (run !== (phase == 4)) begin errors++; $display("FAIL rand_run cyc %0d got %b want %b", n, run, phase == 4); end
            checks++; if (armed !== (phase == 1 || phase == 2)) begin errors++; $display("FAIL rand_armed cyc %0d got %b want %b", n, armed, phase == 1 || phase == 2); end
            if (phase == 1 || phase == 2) begin
                checks++; if (int'(stage) != stg) begin errors++; $display("FAIL rand_stage cyc %0d got %0d want %0d", n, stage, stg); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_prime_stale();
        test_multi_stage();
        test_two_only();
        test_abort_mid();
        test_load_while_armed();
        setup_multi();
        test_load_and_arm();
        test_async_reset();
        test_default_cfg();
`ifdef TRIG_DELAY_EN
        test_delay();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
